// File: rtl/parity_frame_tx.sv
// Serial parity-framed transmitter: accepts a word on load/ready, shifts it out LSB-first,
// then appends one parity bit so every DATA_WIDTH+1 bit frame has the configured parity.
//
// state  | meaning
// IDLE   | no frame in progress, x held at 0
// DATA   | shifting out data bits
// PARITY | driving the parity bit, may accept the next word back-to-back
module parity_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  x,
    output logic                  frame,
    output logic                  par_flag
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  x_q, x_d;
    logic                  frame_q, frame_d;
    logic                  par_q, par_d;
    logic                  accept;

    assign ready    = (state_q != S_DATA);
    assign accept   = load && ready;
    assign x        = x_q;
    assign frame    = frame_q;
    assign par_flag = par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            acc_q   <= 1'b0;
            count_q <= '0;
            x_q     <= 1'b0;
            frame_q <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            x_q     <= x_d;
            frame_q <= frame_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        count_d = count_q;
        x_d     = 1'b0;
        frame_d = 1'b0;
        par_d   = 1'b0;

        case (state_q)
            S_DATA: begin
                // count wraps to 0 once the last data bit has gone out
                if (count_q != '0) begin
                    x_d     = shift_q[0];
                    acc_d   = acc_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    count_d = (count_q == LAST_CNT) ? '0 : count_q + CW'(1);
                    frame_d = 1'b1;
                end else begin
                    state_d = S_PARITY;
                    x_d     = acc_q;
                    frame_d = 1'b1;
                    par_d   = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    state_d = S_DATA;
                    x_d     = data_in[0];
                    frame_d = 1'b1;
                    shift_d = data_in >> 1;
                    acc_d   = ODD_BIT ^ data_in[0];
                    count_d = CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

endmodule
